// File: rtl/icache_mem_responder_pkg.sv
// Shared types and constants for the icache downstream memory responder.
package icache_mem_responder_pkg;

  localparam int unsigned ADDR_W              = 32;
  localparam int unsigned ID_W                = 4;
  localparam int unsigned CNT_W               = 9;
  localparam int unsigned MEM_RSP_LATENCY_DEF = 16;

  // One queued line fill: aligned address, requester id and accept timestamp.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [CNT_W-1:0]  stamp;
  } mem_req_t;

  typedef enum logic {
    StIdle,
    StBeat
  } rsp_state_e;

  // Wrap-safe age of an entry relative to the free-running timer.
  function automatic logic [CNT_W-1:0] req_age(logic [CNT_W-1:0] now, logic [CNT_W-1:0] stamp);
    return now - stamp;
  endfunction

endpackage

// File: rtl/icache_mem_responder_if.sv
// txreq / rxdat bundle between the icache miss path and the memory responder.
interface icache_mem_responder_if #(
  parameter int unsigned ADDR_W = icache_mem_responder_pkg::ADDR_W,
  parameter int unsigned ID_W   = icache_mem_responder_pkg::ID_W,
  parameter int unsigned DATA_W = 256
);
  logic              downstream_txreq_vld;
  logic              downstream_txreq_rdy;
  logic [ADDR_W-1:0] downstream_txreq_pld;
  logic [ID_W-1:0]   downstream_txreq_entry_id;
  logic              downstream_rxdat_vld;
  logic              downstream_rxdat_rdy;
  logic [DATA_W-1:0] downstream_rxdat_pld;
  logic [ID_W-1:0]   downstream_rxdat_txnid;
  logic              downstream_rxdat_last;

  // Requester side (icache).
  modport master (
    output downstream_txreq_vld, downstream_txreq_pld, downstream_txreq_entry_id,
    output downstream_rxdat_rdy,
    input  downstream_txreq_rdy,
    input  downstream_rxdat_vld, downstream_rxdat_pld, downstream_rxdat_txnid,
    input  downstream_rxdat_last
  );

  // Responder side (memory stub).
  modport slave (
    input  downstream_txreq_vld, downstream_txreq_pld, downstream_txreq_entry_id,
    input  downstream_rxdat_rdy,
    output downstream_txreq_rdy,
    output downstream_rxdat_vld, downstream_rxdat_pld, downstream_rxdat_txnid,
    output downstream_rxdat_last
  );
endinterface

// File: rtl/icache_mem_req_fifo.sv
// In-order request queue for the memory responder; head is read combinationally.
module icache_mem_req_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  T                       push_data_i,
  input  logic                   pop_i,
  output T                       head_o,
  output logic [$clog2(Depth):0] count_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  T              mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Next pointers wrap at Depth; count tracks push/pop with simultaneous case neutral.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push_i && pop_i) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/icache_mem_responder.sv
// Downstream memory responder: queues line fills and returns address-derived data
// as LINE_BEATS beats after a fixed minimum latency, strictly in request order.
module icache_mem_responder
  import icache_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned LINE_BEATS = 2,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LATENCY    = MEM_RSP_LATENCY_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  icache_mem_responder_if.slave  bus,
  output logic [$clog2(DEPTH):0] outstanding_cnt
);
  localparam int unsigned WORDS      = DATA_W / 32;
  localparam int unsigned BEAT_BYTES = DATA_W / 8;
  localparam int unsigned LINE_BYTES = BEAT_BYTES * LINE_BEATS;
  localparam int unsigned BEAT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int unsigned CNT_OUT_W  = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

  logic [CNT_W-1:0]     timer_q;
  rsp_state_e           state_q, state_d;
  logic                 vld_q, vld_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic                 push, pop, head_vld, eligible, last_beat, hs;
  mem_req_t             push_req, head_req;
  logic [CNT_OUT_W-1:0] fifo_cnt;
  logic [DATA_W-1:0]    beat_data;
  logic [31:0]          line_word;

  // No bypass: a full queue refuses requests even while popping.
  assign bus.downstream_txreq_rdy = !rst && (fifo_cnt < CNT_OUT_W'(DEPTH));
  assign push = bus.downstream_txreq_vld && bus.downstream_txreq_rdy;

  assign push_req.addr  = bus.downstream_txreq_pld & LINE_MASK;
  assign push_req.id    = bus.downstream_txreq_entry_id;
  assign push_req.stamp = timer_q;

  icache_mem_req_fifo #(
    .T     (mem_req_t),
    .Depth (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_req),
    .pop_i       (pop),
    .head_o      (head_req),
    .count_o     (fifo_cnt)
  );

  assign outstanding_cnt = fifo_cnt;
  assign head_vld        = (fifo_cnt != '0);
  assign eligible        = head_vld && (req_age(timer_q, head_req.stamp) >= CNT_W'(LATENCY));
  assign last_beat       = (beat_q == BEAT_W'(LINE_BEATS - 1));
  assign hs              = vld_q && bus.downstream_rxdat_rdy;

  // Free-running timestamp source; wrap is handled by modular age comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + CNT_W'(1);
    end
  end

  // Return FSM: launch a line when the head ages out, step beats on handshakes.
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (eligible) begin
          vld_d   = 1'b1;
          state_d = StBeat;
        end
      end
      StBeat: begin
        if (hs) begin
          if (last_beat) begin
            pop     = 1'b1;
            beat_d  = '0;
            vld_d   = 1'b0;
            state_d = StIdle;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        vld_d   = 1'b0;
        beat_d  = '0;
      end
    endcase
  end

  // FSM and beat state; reset drops rxdat_vld immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      vld_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      beat_q  <= beat_d;
    end
  end

  // Each 32-bit word carries its own byte address.
  assign line_word = 32'(head_req.addr);
  for (genvar w = 0; w < WORDS; w++) begin : g_word
    assign beat_data[w*32 +: 32] = line_word + (32'(beat_q) * 32'(BEAT_BYTES)) + 32'(4 * w);
  end

  // Payload is masked while idle so outputs read as zero out of reset.
  assign bus.downstream_rxdat_vld   = vld_q;
  assign bus.downstream_rxdat_pld   = vld_q ? beat_data : '0;
  assign bus.downstream_rxdat_txnid = vld_q ? head_req.id : '0;
  assign bus.downstream_rxdat_last  = vld_q && last_beat;

endmodule

// File: tb/tb_icache_mem_responder.sv
// Self-checking bench for icache_mem_responder with a queue-based reference model.
module tb_icache_mem_responder;
  localparam int unsigned DATA_W     = 256;
  localparam int unsigned LINE_BEATS = 2;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned LATENCY    = 16;
  localparam int unsigned WORDS      = DATA_W / 32;
  localparam int unsigned BEAT_BYTES = DATA_W / 8;
  localparam logic [31:0] LINE_MASK  = ~32'(BEAT_BYTES * LINE_BEATS - 1);

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    int          acc;
  } exp_line_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] outstanding_cnt;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  icache_mem_responder_if bus ();

  icache_mem_responder #(
    .DATA_W     (DATA_W),
    .LINE_BEATS (LINE_BEATS),
    .DEPTH      (DEPTH),
    .LATENCY    (LATENCY)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .outstanding_cnt (outstanding_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: word w of beat b is the word's own byte address within the aligned line.
  function automatic logic [31:0] exp_word(logic [31:0] addr, int b, int w);
    return (addr & LINE_MASK) + 32'(b * BEAT_BYTES + 4 * w);
  endfunction

  function automatic logic [31:0] pld_word(int w);
    return bus.downstream_rxdat_pld[w*32 +: 32];
  endfunction

  task automatic send_one(input logic [31:0] addr, input logic [3:0] id, output int acc,
                          output bit ok);
    ok  = 1'b0;
    acc = 0;
    @(negedge clk);
    bus.downstream_txreq_vld      = 1'b1;
    bus.downstream_txreq_pld      = addr;
    bus.downstream_txreq_entry_id = id;
    for (int i = 0; i < 50; i++) begin
      if (bus.downstream_txreq_rdy) begin
        ok  = 1'b1;
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.downstream_txreq_vld = 1'b0;
  endtask

  task automatic wait_vld(input int limit, output int seen, output bit ok);
    ok   = 1'b0;
    seen = 0;
    for (int i = 0; i < limit; i++) begin
      if (bus.downstream_rxdat_vld) begin
        ok   = 1'b1;
        seen = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.downstream_txreq_vld      = 1'b0;
    bus.downstream_txreq_pld      = '0;
    bus.downstream_txreq_entry_id = '0;
    bus.downstream_rxdat_rdy      = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.downstream_rxdat_vld !== 1'b0 || bus.downstream_txreq_rdy !== 1'b0 ||
        outstanding_cnt !== 4'd0 || bus.downstream_rxdat_last !== 1'b0 ||
        bus.downstream_rxdat_txnid !== 4'd0 || bus.downstream_rxdat_pld !== '0) begin
      errors++;
      $display("FAIL reset_outputs: vld=%b rdy=%b cnt=%0d last=%b txnid=%0d want all 0",
               bus.downstream_rxdat_vld, bus.downstream_txreq_rdy, outstanding_cnt,
               bus.downstream_rxdat_last, bus.downstream_rxdat_txnid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.downstream_txreq_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rdy: got %b want 1", bus.downstream_txreq_rdy);
    end
  endtask

  // Single line: latency, word values, last and txnid.
  task automatic test_single(input logic [31:0] addr, input logic [3:0] id,
                             input logic [31:0] w0_b0, input logic [31:0] w0_b1);
    int acc, seen;
    bit ok, okv;
    bus.downstream_rxdat_rdy = 1'b1;
    send_one(addr, id, acc, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_accept: got no accept want accept");
    end
    wait_vld(60, seen, okv);
    checks++;
    if (!okv || (seen - acc) != int'(LATENCY)) begin
      errors++;
      $display("FAIL single_latency: got %0d (seen=%0b) want %0d", seen - acc, okv, LATENCY);
    end
    if (okv) begin
      checks++;
      if (pld_word(0) !== w0_b0 || pld_word(7) !== w0_b0 + 32'h1C ||
          bus.downstream_rxdat_last !== 1'b0 || bus.downstream_rxdat_txnid !== id) begin
        errors++;
        $display("FAIL single_beat0: got w0=%h w7=%h last=%b id=%0d want %h %h 0 %0d",
                 pld_word(0), pld_word(7), bus.downstream_rxdat_last,
                 bus.downstream_rxdat_txnid, w0_b0, w0_b0 + 32'h1C, id);
      end
      @(negedge clk);
      checks++;
      if (bus.downstream_rxdat_vld !== 1'b1 || pld_word(0) !== w0_b1 ||
          bus.downstream_rxdat_last !== 1'b1 || bus.downstream_rxdat_txnid !== id) begin
        errors++;
        $display("FAIL single_beat1: got vld=%b w0=%h last=%b id=%0d want 1 %h 1 %0d",
                 bus.downstream_rxdat_vld, pld_word(0), bus.downstream_rxdat_last,
                 bus.downstream_rxdat_txnid, w0_b1, id);
      end
      @(negedge clk);
      checks++;
      if (bus.downstream_rxdat_vld !== 1'b0 || outstanding_cnt !== 4'd0) begin
        errors++;
        $display("FAIL single_drain: got vld=%b cnt=%0d want 0 0",
                 bus.downstream_rxdat_vld, outstanding_cnt);
      end
    end
  endtask

  // Fill the queue under backpressure, then drain and watch the freed slot.
  task automatic test_full();
    int next_id = 0, beat = 0, pop_cyc = -1, acc9 = -1;
    bit pend = 1'b1;
    bus.downstream_rxdat_rdy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.downstream_txreq_vld      = 1'b1;
      bus.downstream_txreq_pld      = 32'h4000 + 32'(i * 64);
      bus.downstream_txreq_entry_id = 4'(i);
      checks++;
      if (bus.downstream_txreq_rdy !== (i < 8)) begin
        errors++;
        $display("FAIL full_rdy_%0d: got %b want %b", i, bus.downstream_txreq_rdy, i < 8);
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (outstanding_cnt !== 4'd8 || bus.downstream_txreq_rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_count: got cnt=%0d rdy=%b want 8 0",
               outstanding_cnt, bus.downstream_txreq_rdy);
    end
    bus.downstream_rxdat_rdy = 1'b1;
    for (int c = 0; c < 400 && next_id < 9; c++) begin
      if (!pend) bus.downstream_txreq_vld = 1'b0;
      if (pend && bus.downstream_txreq_rdy) begin
        acc9 = cyc + 1;
        pend = 1'b0;
      end
      if (bus.downstream_rxdat_vld) begin
        checks++;
        if (bus.downstream_rxdat_txnid !== 4'(next_id) ||
            pld_word(0) !== exp_word(32'h4000 + 32'(next_id * 64), beat, 0)) begin
          errors++;
          $display("FAIL full_order: got id=%0d w0=%h want id=%0d w0=%h",
                   bus.downstream_rxdat_txnid, pld_word(0), next_id,
                   exp_word(32'h4000 + 32'(next_id * 64), beat, 0));
        end
        if (beat == LINE_BEATS - 1) begin
          if (pop_cyc < 0) pop_cyc = cyc + 1;
          next_id++;
          beat = 0;
        end else begin
          beat++;
        end
      end
      @(negedge clk);
    end
    bus.downstream_txreq_vld = 1'b0;
    checks++;
    if (next_id != 9) begin
      errors++;
      $display("FAIL full_lines: got %0d want 9", next_id);
    end
    checks++;
    if (acc9 != pop_cyc + 1) begin
      errors++;
      $display("FAIL full_ninth_accept: got cycle %0d want %0d", acc9, pop_cyc + 1);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (outstanding_cnt !== 4'd0) begin
      errors++;
      $display("FAIL full_drain_cnt: got %0d want 0", outstanding_cnt);
    end
  endtask

  // Random traffic and backpressure against a queue model.
  task automatic test_random();
    exp_line_t q[$];
    exp_line_t e;
    int pushed = 0, lines = 0, beat = 0;
    bit stall = 1'b0, seen0 = 1'b0, bad;
    logic [DATA_W-1:0] s_pld;
    logic [3:0] s_id;
    logic s_last, rr;
    @(negedge clk);
    for (int c = 0; c < 6000 && lines < 100; c++) begin
      checks++;
      if (outstanding_cnt !== 4'(q.size())) begin
        errors++;
        $display("FAIL rand_count: got %0d want %0d", outstanding_cnt, q.size());
      end
      if (stall) begin
        checks++;
        if (bus.downstream_rxdat_vld !== 1'b1 || bus.downstream_rxdat_pld !== s_pld ||
            bus.downstream_rxdat_txnid !== s_id || bus.downstream_rxdat_last !== s_last) begin
          errors++;
          $display("FAIL rand_stable: got vld=%b id=%0d last=%b want held beat id=%0d last=%b",
                   bus.downstream_rxdat_vld, bus.downstream_rxdat_txnid,
                   bus.downstream_rxdat_last, s_id, s_last);
        end
      end
      rr = ($urandom_range(0, 2) != 0);
      bus.downstream_rxdat_rdy = rr;
      if (bus.downstream_rxdat_vld) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious: got vld=1 want 0 with empty model");
        end else begin
          bad = 1'b0;
          for (int w = 0; w < int'(WORDS); w++) begin
            if (pld_word(w) !== exp_word(q[0].addr, beat, w)) bad = 1'b1;
          end
          if (bad || bus.downstream_rxdat_txnid !== q[0].id ||
              bus.downstream_rxdat_last !== (beat == LINE_BEATS - 1)) begin
            errors++;
            $display("FAIL rand_beat: got id=%0d w0=%h last=%b want id=%0d w0=%h last=%b",
                     bus.downstream_rxdat_txnid, pld_word(0), bus.downstream_rxdat_last,
                     q[0].id, exp_word(q[0].addr, beat, 0), beat == LINE_BEATS - 1);
          end
          if (beat == 0 && !seen0) begin
            seen0 = 1'b1;
            checks++;
            if (cyc - q[0].acc < int'(LATENCY)) begin
              errors++;
              $display("FAIL rand_latency: got %0d want >= %0d", cyc - q[0].acc, LATENCY);
            end
          end
        end
      end
      stall  = bus.downstream_rxdat_vld && !rr;
      s_pld  = bus.downstream_rxdat_pld;
      s_id   = bus.downstream_rxdat_txnid;
      s_last = bus.downstream_rxdat_last;
      if (bus.downstream_rxdat_vld && rr && q.size() > 0) begin
        if (beat == LINE_BEATS - 1) begin
          void'(q.pop_front());
          lines++;
          beat  = 0;
          seen0 = 1'b0;
        end else begin
          beat++;
        end
      end
      bus.downstream_txreq_vld      = (pushed < 100) && ($urandom_range(0, 1) == 1);
      bus.downstream_txreq_pld      = $urandom;
      bus.downstream_txreq_entry_id = 4'($urandom_range(0, 15));
      if (bus.downstream_txreq_vld && bus.downstream_txreq_rdy) begin
        e.addr = bus.downstream_txreq_pld;
        e.id   = bus.downstream_txreq_entry_id;
        e.acc  = cyc + 1;
        q.push_back(e);
        pushed++;
      end
      @(negedge clk);
    end
    bus.downstream_txreq_vld = 1'b0;
    bus.downstream_rxdat_rdy = 1'b1;
    checks++;
    if (lines != 100 || pushed != 100) begin
      errors++;
      $display("FAIL rand_lines: got lines=%0d pushed=%0d want 100 100", lines, pushed);
    end
  endtask

  // Reset during beat 1 with requests queued behind the active line.
  task automatic test_reset_mid();
    int acc, seen;
    bit ok, okv;
    bus.downstream_rxdat_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.downstream_txreq_vld      = 1'b1;
      bus.downstream_txreq_pld      = 32'h6000 + 32'(i * 64);
      bus.downstream_txreq_entry_id = 4'(10 + i);
    end
    @(negedge clk);
    bus.downstream_txreq_vld = 1'b0;
    wait_vld(60, seen, okv);
    @(negedge clk);
    checks++;
    if (!okv || bus.downstream_rxdat_last !== 1'b1 || outstanding_cnt !== 4'd4) begin
      errors++;
      $display("FAIL rstmid_setup: got vld_seen=%b last=%b cnt=%0d want 1 1 4",
               okv, bus.downstream_rxdat_last, outstanding_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.downstream_rxdat_vld !== 1'b0 || bus.downstream_rxdat_pld !== '0 ||
        bus.downstream_txreq_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got vld=%b rdy=%b want 0 0",
               bus.downstream_rxdat_vld, bus.downstream_txreq_rdy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (outstanding_cnt !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_cnt: got %0d want 0", outstanding_cnt);
    end
    send_one(32'h8000, 4'd9, acc, ok);
    wait_vld(60, seen, okv);
    checks++;
    if (!ok || !okv || (seen - acc) != int'(LATENCY) || bus.downstream_rxdat_txnid !== 4'd9 ||
        pld_word(0) !== 32'h8000) begin
      errors++;
      $display("FAIL rstmid_new: got lat=%0d id=%0d w0=%h want %0d 9 00008000",
               seen - acc, bus.downstream_rxdat_txnid, pld_word(0), LATENCY);
    end
    repeat (3) @(negedge clk);
  endtask

  // Let the timer wrap before issuing a request.
  task automatic test_wrap();
    int acc, seen, spurious = 0;
    bit ok, okv;
    bus.downstream_rxdat_rdy = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.downstream_rxdat_vld) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL wrap_idle: got %0d vld cycles want 0", spurious);
    end
    send_one(32'h0001_F000, 4'd2, acc, ok);
    wait_vld(60, seen, okv);
    checks++;
    if (!ok || !okv || (seen - acc) != int'(LATENCY) || pld_word(0) !== 32'h0001_F000) begin
      errors++;
      $display("FAIL wrap_latency: got lat=%0d w0=%h want %0d 0001f000",
               seen - acc, pld_word(0), LATENCY);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single(32'h1000, 4'd3, 32'h1000, 32'h1020);
    test_single(32'h1234, 4'd5, 32'h1200, 32'h1220);
    test_full();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
